tag_sync_multi: RTL and testbench
=================================

Name: tag_sync_multi

Overview:
- N-way tag sequencer for multi-buffered on-chip memories; generalises the two-deep double-buffer tag sync to any NUM_TAGS.
- Sits between the instruction decoder and the ldmem/compute/stmem engines. Each buffer tag moves FREE -> LDMEM -> COMPUTE -> STMEM -> FREE.
- New over the previous generation: a per-tag use counter, so one loaded buffer can serve up to MAX_USES compute passes, and a STORE_ENABLED=0 mode that frees tags directly after compute.

Parameters:
- NUM_TAGS, 4, number of buffer tags; any value >= 2, not restricted to powers of two.
- TAG_W, $clog2(NUM_TAGS), tag index width.
- STORE_ENABLED, 1, 1 = tags pass through STMEM; 0 = COMPUTE -> FREE and all stmem outputs tie to 0.
- MAX_USES, 4, maximum outstanding compute passes per tag.
- USE_W, $clog2(MAX_USES+1), use-counter width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- tag_req  in  1  request a tag
- tag_reuse  in  1  qualifies tag_req: reuse the previous tag instead of allocating
- tag_bias_prev_sw  in  1  captured on new allocation
- tag_ddr_pe_sw  in  1  captured on new allocation
- block_done  in  1  seals the previous tag
- tag_ready  out  1  request can be accepted this cycle
- tag  out  TAG_W  granted tag
- tag_done  out  1  all tags FREE
- ldmem_tag_done  in  1  load complete for ldmem_tag
- ldmem_tag_ready  out  1  ldmem_tag is in LDMEM
- ldmem_tag  out  TAG_W  round-robin load pointer
- compute_tag_done  in  1  one compute pass complete on compute_tag
- compute_tag_ready  out  1  compute_tag is in COMPUTE with uses > 0
- compute_bias_prev_sw  out  1  captured bias flag of compute_tag
- compute_tag  out  TAG_W  round-robin compute pointer
- stmem_tag_done  in  1  store complete for stmem_tag
- stmem_tag_ready  out  1  stmem_tag is in STMEM
- stmem_ddr_pe_sw  out  1  captured ddr_pe flag of stmem_tag
- stmem_tag  out  TAG_W  round-robin store pointer
- raw_stmem_tag  in  TAG_W  arbitrary tag query
- raw_stmem_tag_ready  out  1  the queried tag is in STMEM
- tag_state  out  2*NUM_TAGS  per-tag state, tag t at bits [2t+1:2t]

Behaviour:
- State encoding: FREE=0, LDMEM=1, COMPUTE=2, STMEM=3.
- Per-tag registers: state, uses (USE_W bits), sealed, bias, ddr.
- Global registers: alloc_ptr, prev_tag, prev_valid, ld_ptr, cmp_ptr, st_ptr.
- Reset (reset=0 at clk edge): all tags FREE; uses=0; sealed=1; all pointers 0; prev_valid=0.
- Outputs after reset: tag_ready=1, tag=0, tag_done=1, tag_state=0; every *_ready output is 0.
- New request (tag_req & ~tag_reuse):
  - tag_ready = (state[alloc_ptr]==FREE); tag = alloc_ptr.
  - On accept, at the next edge: state -> LDMEM, uses=1, sealed=0, bias/ddr captured.
  - Also on accept: prev_tag=alloc_ptr; prev_valid=1; alloc_ptr increments, wrapping NUM_TAGS-1 -> 0.
- Reuse request (tag_req & tag_reuse):
  - tag = prev_tag.
  - tag_ready = prev_valid & ~sealed[prev_tag] & state[prev_tag] in {LDMEM, COMPUTE} & uses[prev_tag] < MAX_USES.
  - On accept: uses[prev_tag]++. No pointer moves.
- Seal:
  - An accepted new request seals the old prev_tag in the same edge it allocates the new one.
  - block_done seals prev_tag when prev_valid=1.
  - Sealing an already-sealed tag has no effect.
- LDMEM -> COMPUTE: on ldmem_tag_done while ldmem_tag_ready=1; ld_ptr wraps.
- COMPUTE:
  - compute_tag_done while compute_tag_ready=1 decrements uses.
  - The tag leaves COMPUTE on the edge where next-uses==0 and next-sealed==1. The seal may arrive in the same cycle as the final done, or any later cycle.
  - Destination: STMEM (STORE_ENABLED=1) or FREE (STORE_ENABLED=0). cmp_ptr advances on that edge.
  - With uses==0 and unsealed, the tag holds in COMPUTE with compute_tag_ready=0.
- STMEM -> FREE: on stmem_tag_done while stmem_tag_ready=1; st_ptr wraps.
- Ignored inputs: any *_done asserted while its ready is 0 is ignored. tag_req while tag_ready=0 is not accepted.
- Simultaneous events:
  - Reuse accept and compute_tag_done on the same tag: uses is unchanged.
  - Events on different tags are independent, so every tag may transition in the same cycle.
- Latency: all ready/tag outputs are combinational from registered state; every transition takes effect one edge after its qualifying cycle.
- Reset mid-operation returns the block to the reset state in one edge; in-flight dones in that cycle are discarded.

Test Plan:
- Reset release, NUM_TAGS=4 -> tag_ready=1, tag=0, tag_done=1, tag_state=0.
- 4 new requests back-to-back -> tags 0,1,2,3 granted; 5th request stalls (tag_ready=0). ldmem_tag_done on 0 and compute_tag_done on 0 with seal -> stmem_tag_ready=1; after stmem_tag_done -> tag 0 re-granted.
- New request then 3 reuses -> uses[0]=4 and a 5th reuse stalls. Four compute_tag_done pulses with no seal -> tag 0 holds in COMPUTE with compute_tag_ready=0. block_done -> tag 0 enters STMEM next edge.
- Final compute_tag_done and block_done in the same cycle -> tag 0 goes to STMEM in one edge. Reuse and done in the same cycle -> uses unchanged.
- STORE_ENABLED=0 -> a COMPUTE exit goes straight to FREE; stmem_tag_ready and raw_stmem_tag_ready stay 0.
- reset=0 asserted with tags in LDMEM/COMPUTE/STMEM and dones pending -> next cycle tag_state=0 and all pointers 0.

Source files
------------

// File: rtl/tag_sync_multi_if.sv
// tag_sync_multi_if: decoder-side request bus plus ldmem/compute/stmem engine handshakes.
interface tag_sync_multi_if #(
  parameter int NUM_TAGS = 4,
  parameter int TAG_W    = $clog2(NUM_TAGS)
);
  logic                  tag_req, tag_reuse, tag_bias_prev_sw, tag_ddr_pe_sw, block_done;
  logic                  tag_ready, tag_done;
  logic [TAG_W-1:0]      tag;
  logic                  ldmem_tag_done, ldmem_tag_ready;
  logic [TAG_W-1:0]      ldmem_tag;
  logic                  compute_tag_done, compute_tag_ready, compute_bias_prev_sw;
  logic [TAG_W-1:0]      compute_tag;
  logic                  stmem_tag_done, stmem_tag_ready, stmem_ddr_pe_sw;
  logic [TAG_W-1:0]      stmem_tag, raw_stmem_tag;
  logic                  raw_stmem_tag_ready;
  logic [2*NUM_TAGS-1:0] tag_state;
  modport master (
    output tag_req, tag_reuse, tag_bias_prev_sw, tag_ddr_pe_sw, block_done,
           ldmem_tag_done, compute_tag_done, stmem_tag_done, raw_stmem_tag,
    input  tag_ready, tag, tag_done, ldmem_tag_ready, ldmem_tag, compute_tag_ready,
           compute_bias_prev_sw, compute_tag, stmem_tag_ready, stmem_ddr_pe_sw, stmem_tag,
           raw_stmem_tag_ready, tag_state
  );
  modport slave (
    input  tag_req, tag_reuse, tag_bias_prev_sw, tag_ddr_pe_sw, block_done,
           ldmem_tag_done, compute_tag_done, stmem_tag_done, raw_stmem_tag,
    output tag_ready, tag, tag_done, ldmem_tag_ready, ldmem_tag, compute_tag_ready,
           compute_bias_prev_sw, compute_tag, stmem_tag_ready, stmem_ddr_pe_sw, stmem_tag,
           raw_stmem_tag_ready, tag_state
  );
endinterface

// File: rtl/tag_sync_multi.sv
// tag_sync_multi: N-way buffer tag sequencer FREE -> LDMEM -> COMPUTE -> (STMEM) -> FREE
// with a per-tag use counter so one load can feed several compute passes.
module tag_sync_multi #(
  parameter int NUM_TAGS      = 4,
  parameter int TAG_W         = $clog2(NUM_TAGS),
  parameter bit STORE_ENABLED = 1,
  parameter int MAX_USES      = 4,
  parameter int USE_W         = $clog2(MAX_USES+1)
) (
  input logic            clk,
  input logic            reset,
  tag_sync_multi_if.slave bus
);
  typedef enum logic [1:0] {FREE = 2'd0, LDMEM = 2'd1, COMPUTE = 2'd2, STMEM = 2'd3} tag_st_e;
  tag_st_e             state_q [NUM_TAGS];
  tag_st_e             state_d [NUM_TAGS];
  logic [USE_W-1:0]    uses_q [NUM_TAGS];
  logic [USE_W-1:0]    uses_d [NUM_TAGS];
  logic [NUM_TAGS-1:0] sealed_q, sealed_d, bias_q, bias_d, ddr_q, ddr_d;
  logic [TAG_W-1:0]    alloc_ptr_q, alloc_ptr_d, prev_tag_q, prev_tag_d;
  logic [TAG_W-1:0]    ld_ptr_q, ld_ptr_d, cmp_ptr_q, cmp_ptr_d, st_ptr_q, st_ptr_d;
  logic                prev_valid_q, prev_valid_d;
  logic                new_ok, reuse_ok, acc_new, acc_reuse, seal_prev;
  logic                ld_ready, cmp_ready, st_ready, ld_fire, cmp_fire, st_fire, cmp_exit;

  function automatic logic [TAG_W-1:0] wrap_inc(input logic [TAG_W-1:0] p);
    return (p == TAG_W'(NUM_TAGS-1)) ? '0 : p + TAG_W'(1);
  endfunction

  always_comb begin
    new_ok    = state_q[alloc_ptr_q] == FREE;
    reuse_ok  = prev_valid_q && !sealed_q[prev_tag_q] && (state_q[prev_tag_q] inside {LDMEM, COMPUTE})
                && uses_q[prev_tag_q] < USE_W'(MAX_USES);
    acc_new   = bus.tag_req && !bus.tag_reuse && new_ok;
    acc_reuse = bus.tag_req && bus.tag_reuse && reuse_ok;
    seal_prev = prev_valid_q && (acc_new || bus.block_done);
    ld_ready  = state_q[ld_ptr_q] == LDMEM;
    cmp_ready = state_q[cmp_ptr_q] == COMPUTE && uses_q[cmp_ptr_q] != '0;
    st_ready  = STORE_ENABLED && state_q[st_ptr_q] == STMEM;
    ld_fire   = bus.ldmem_tag_done && ld_ready;
    cmp_fire  = bus.compute_tag_done && cmp_ready;
    st_fire   = bus.stmem_tag_done && st_ready;
    bus.tag_ready            = bus.tag_reuse ? reuse_ok : new_ok;
    bus.tag                  = bus.tag_reuse ? prev_tag_q : alloc_ptr_q;
    bus.ldmem_tag_ready      = ld_ready;
    bus.ldmem_tag            = ld_ptr_q;
    bus.compute_tag_ready    = cmp_ready;
    bus.compute_bias_prev_sw = bias_q[cmp_ptr_q];
    bus.compute_tag          = cmp_ptr_q;
    bus.stmem_tag_ready      = st_ready;
    bus.stmem_ddr_pe_sw      = STORE_ENABLED && ddr_q[st_ptr_q];
    bus.stmem_tag            = STORE_ENABLED ? st_ptr_q : '0;
    bus.raw_stmem_tag_ready  = STORE_ENABLED && int'(bus.raw_stmem_tag) < NUM_TAGS
                               && state_q[bus.raw_stmem_tag] == STMEM;
    bus.tag_done  = 1'b1;
    bus.tag_state = '0;
    for (int t = 0; t < NUM_TAGS; t++) begin
      bus.tag_done           = bus.tag_done && state_q[t] == FREE;
      bus.tag_state[2*t +: 2] = state_q[t];
      state_d[t]  = state_q[t];
      // a reuse and a finished pass on the same tag cancel out
      uses_d[t]   = uses_q[t] + USE_W'(acc_reuse && prev_tag_q == TAG_W'(t))
                              - USE_W'(cmp_fire && cmp_ptr_q == TAG_W'(t));
      sealed_d[t] = sealed_q[t] || (seal_prev && prev_tag_q == TAG_W'(t));
      bias_d[t]   = bias_q[t];
      ddr_d[t]    = ddr_q[t];
      if (acc_new && alloc_ptr_q == TAG_W'(t)) begin
        state_d[t]  = LDMEM;
        uses_d[t]   = USE_W'(1);
        sealed_d[t] = 1'b0;
        bias_d[t]   = bus.tag_bias_prev_sw;
        ddr_d[t]    = bus.tag_ddr_pe_sw;
      end
      if (ld_fire && ld_ptr_q == TAG_W'(t)) state_d[t] = COMPUTE;
      if (st_fire && st_ptr_q == TAG_W'(t)) state_d[t] = FREE;
    end
    // only the compute-pointer tag can drain its uses, so only it can exit
    cmp_exit = state_q[cmp_ptr_q] == COMPUTE && uses_d[cmp_ptr_q] == '0 && sealed_d[cmp_ptr_q];
    if (cmp_exit) state_d[cmp_ptr_q] = STORE_ENABLED ? STMEM : FREE;
    alloc_ptr_d  = acc_new ? wrap_inc(alloc_ptr_q) : alloc_ptr_q;
    prev_tag_d   = acc_new ? alloc_ptr_q : prev_tag_q;
    prev_valid_d = prev_valid_q || acc_new;
    ld_ptr_d     = ld_fire ? wrap_inc(ld_ptr_q) : ld_ptr_q;
    cmp_ptr_d    = cmp_exit ? wrap_inc(cmp_ptr_q) : cmp_ptr_q;
    st_ptr_d     = st_fire ? wrap_inc(st_ptr_q) : st_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int t = 0; t < NUM_TAGS; t++) begin
        state_q[t] <= FREE;
        uses_q[t]  <= '0;
      end
      sealed_q     <= '1;
      bias_q       <= '0;
      ddr_q        <= '0;
      alloc_ptr_q  <= '0;
      prev_tag_q   <= '0;
      prev_valid_q <= 1'b0;
      ld_ptr_q     <= '0;
      cmp_ptr_q    <= '0;
      st_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      uses_q       <= uses_d;
      sealed_q     <= sealed_d;
      bias_q       <= bias_d;
      ddr_q        <= ddr_d;
      alloc_ptr_q  <= alloc_ptr_d;
      prev_tag_q   <= prev_tag_d;
      prev_valid_q <= prev_valid_d;
      ld_ptr_q     <= ld_ptr_d;
      cmp_ptr_q    <= cmp_ptr_d;
      st_ptr_q     <= st_ptr_d;
    end
  end
endmodule

// File: tb/tb_tag_sync_multi.sv
// tb_tag_sync_multi: two DUTs (store on / store off) on shared stimulus, checked each cycle
// against a count-based tag lifecycle model, plus directed literal checks.
module tb_tag_sync_multi;
  localparam int N = 4, TW = 2, MU = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic req, reuse, bias, ddr, bdone, lddone, cdone, sdone;
  logic [TW-1:0] raw;
  int ncmp = 0, nerr = 0;

  tag_sync_multi_if #(.NUM_TAGS(N)) if0 (), if1 ();
  assign {if0.tag_req, if0.tag_reuse, if0.tag_bias_prev_sw, if0.tag_ddr_pe_sw, if0.block_done,
          if0.ldmem_tag_done, if0.compute_tag_done, if0.stmem_tag_done, if0.raw_stmem_tag} =
         {req, reuse, bias, ddr, bdone, lddone, cdone, sdone, raw};
  assign {if1.tag_req, if1.tag_reuse, if1.tag_bias_prev_sw, if1.tag_ddr_pe_sw, if1.block_done,
          if1.ldmem_tag_done, if1.compute_tag_done, if1.stmem_tag_done, if1.raw_stmem_tag} =
         {req, reuse, bias, ddr, bdone, lddone, cdone, sdone, raw};

  tag_sync_multi #(.NUM_TAGS(N), .STORE_ENABLED(1), .MAX_USES(MU)) d0 (.clk(clk), .reset(rst_n), .bus(if0));
  tag_sync_multi #(.NUM_TAGS(N), .STORE_ENABLED(0), .MAX_USES(MU)) d1 (.clk(clk), .reset(rst_n), .bus(if1));

  logic [23:0] dv [2];
  assign dv[0] = {if0.tag_ready, if0.tag, if0.tag_done, if0.ldmem_tag_ready, if0.ldmem_tag,
                  if0.compute_tag_ready, if0.compute_bias_prev_sw, if0.compute_tag, if0.stmem_tag_ready,
                  if0.stmem_ddr_pe_sw, if0.stmem_tag, if0.raw_stmem_tag_ready, if0.tag_state};
  assign dv[1] = {if1.tag_ready, if1.tag, if1.tag_done, if1.ldmem_tag_ready, if1.ldmem_tag,
                  if1.compute_tag_ready, if1.compute_bias_prev_sw, if1.compute_tag, if1.stmem_tag_ready,
                  if1.stmem_ddr_pe_sw, if1.stmem_tag, if1.raw_stmem_tag_ready, if1.tag_state};

  // model: per-tag stage (0 free,1 load,2 compute,3 store), uses, seal, flags; engine
  // pointers are the number of completed stage exits modulo N
  int st [2][N];
  int us [2][N];
  bit sl [2][N];
  bit bi [2][N];
  bit dd [2][N];
  bit pv [2];
  int prv [2], na [2], nl [2], nc [2], ns [2];
  bit live = 1'b0;

  function automatic logic [23:0] expv(int m);
    bit se = (m == 0);
    int a = na[m] % N, l = nl[m] % N, c = nc[m] % N, s = ns[m] % N, p = prv[m];
    logic ok_new, ok_re, alldone;
    logic [7:0] ts;
    ok_new = st[m][a] == 0;
    ok_re = pv[m] && !sl[m][p] && (st[m][p] == 1 || st[m][p] == 2) && us[m][p] < MU;
    alldone = 1'b1;
    ts = '0;
    for (int t = 0; t < N; t++) begin
      ts[2*t +: 2] = 2'(st[m][t]);
      if (st[m][t] != 0) alldone = 1'b0;
    end
    return {reuse ? ok_re : ok_new, reuse ? 2'(p) : 2'(a), alldone, st[m][l] == 1, 2'(l),
            st[m][c] == 2 && us[m][c] > 0, bi[m][c], 2'(c), se && st[m][s] == 3,
            se && dd[m][s], se ? 2'(s) : 2'd0, se && st[m][raw] == 3, ts};
  endfunction

  task automatic model_step(int m);
    bit se = (m == 0);
    int a = na[m] % N, l = nl[m] % N, c = nc[m] % N, s = ns[m] % N, p = prv[m];
    bit acc_new, acc_re, ldf, cf, sf, cin;
    if (!rst_n) begin
      for (int t = 0; t < N; t++) begin
        st[m][t] = 0; us[m][t] = 0; sl[m][t] = 1'b1; bi[m][t] = 1'b0; dd[m][t] = 1'b0;
      end
      prv[m] = 0; pv[m] = 1'b0; na[m] = 0; nl[m] = 0; nc[m] = 0; ns[m] = 0;
      return;
    end
    acc_new = req && !reuse && st[m][a] == 0;
    acc_re = req && reuse && pv[m] && !sl[m][p] && (st[m][p] == 1 || st[m][p] == 2) && us[m][p] < MU;
    ldf = lddone && st[m][l] == 1;
    cf = cdone && st[m][c] == 2 && us[m][c] > 0;
    sf = se && sdone && st[m][s] == 3;
    cin = st[m][c] == 2;
    if (acc_re) us[m][p]++;
    if (cf) us[m][c]--;
    if (pv[m] && (acc_new || bdone)) sl[m][p] = 1'b1;
    if (acc_new) begin
      st[m][a] = 1; us[m][a] = 1; sl[m][a] = 1'b0; bi[m][a] = bias; dd[m][a] = ddr;
      prv[m] = a; pv[m] = 1'b1; na[m]++;
    end
    if (ldf) begin st[m][l] = 2; nl[m]++; end
    if (cin && us[m][c] == 0 && sl[m][c]) begin st[m][c] = se ? 3 : 0; nc[m]++; end
    if (sf) begin st[m][s] = 0; ns[m]++; end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    if (!rst_n) live = 1'b1;
  end

  always @(negedge clk) begin
    if (live) begin
      for (int m = 0; m < 2; m++) begin
        logic [23:0] e;
        e = expv(m);
        ncmp++;
        if (dv[m] !== e) begin
          nerr++;
          $display("FAIL outputs dut%0d @%0t: got %h expected %h", m, $time, dv[m], e);
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic idle();
    {req, reuse, bias, ddr, bdone, lddone, cdone, sdone} = '0;
    raw = '0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [23:0] mv;
    idle();
    tick();
    do_reset();
    #1;
    chk("reset tag_ready", if0.tag_ready, 1);
    chk("reset tag", if0.tag, 0);
    chk("reset tag_done", if0.tag_done, 1);
    chk("reset tag_state", if0.tag_state, 0);
    chk("reset readies", {if0.ldmem_tag_ready, if0.compute_tag_ready, if0.stmem_tag_ready,
                          if0.raw_stmem_tag_ready}, 0);
    // fill all four tags
    for (int i = 0; i < N; i++) begin
      req = 1'b1; bias = 1'(i % 2); ddr = 1'(i % 2 == 0);
      #1;
      chk("grant tag", if0.tag, i);
      chk("grant ready", if0.tag_ready, 1);
      tick();
    end
    #1;
    chk("fifth request stalls", if0.tag_ready, 0);
    chk("all ldmem", if0.tag_state, 8'h55);
    mv = expv(0);
    chk("model all ldmem", mv[7:0], 8'h55);
    idle(); lddone = 1'b1;
    #1;
    chk("ldmem ready", {if0.ldmem_tag_ready, if0.ldmem_tag}, 3'b100);
    tick(); idle();
    #1;
    chk("compute ready", {if0.compute_tag_ready, if0.compute_bias_prev_sw, if0.compute_tag}, 4'b1000);
    cdone = 1'b1;
    tick(); idle();
    #1;
    chk("stmem ready", {if0.stmem_tag_ready, if0.stmem_ddr_pe_sw, if0.stmem_tag}, 4'b1100);
    chk("store state", if0.tag_state, 8'h57);
    chk("nostore state", if1.tag_state, 8'h54);
    chk("nostore stmem ready", {if1.stmem_tag_ready, if1.raw_stmem_tag_ready}, 0);
    chk("raw query", if0.raw_stmem_tag_ready, 1);
    mv = expv(1);
    chk("model nostore", mv[7:0], 8'h54);
    sdone = 1'b1;
    tick(); idle(); req = 1'b1;
    #1;
    chk("regrant tag 0", {if0.tag_ready, if0.tag}, 3'b100);
    tick();
    // reuse up to the limit, then drain without a seal
    do_reset(); req = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      reuse = 1'b1;
      #1;
      chk("reuse grant", {if0.tag_ready, if0.tag}, 3'b100);
      tick();
    end
    #1;
    chk("reuse at max stalls", if0.tag_ready, 0);
    idle(); lddone = 1'b1;
    tick(); idle();
    for (int k = 0; k < 4; k++) begin
      cdone = 1'b1;
      #1;
      chk("pass ready", if0.compute_tag_ready, 1);
      tick(); idle();
    end
    #1;
    chk("drained unsealed ready", if0.compute_tag_ready, 0);
    chk("drained unsealed state", if0.tag_state, 8'h02);
    bdone = 1'b1;
    tick(); idle();
    #1;
    chk("seal -> stmem", if0.tag_state, 8'h03);
    chk("seal -> free", {if1.tag_done, if1.tag_state}, 9'h100);
    // reuse and done together, then final done with seal together
    do_reset(); req = 1'b1;
    tick(); idle(); lddone = 1'b1;
    tick(); idle(); req = 1'b1; reuse = 1'b1; cdone = 1'b1;
    tick(); idle();
    #1;
    chk("reuse+done keeps uses", if0.compute_tag_ready, 1);
    cdone = 1'b1; bdone = 1'b1;
    tick(); idle();
    #1;
    chk("done+seal same cycle", if0.tag_state, 8'h03);
    chk("done+seal nostore", if1.tag_state, 8'h00);
    // reset with work in flight
    do_reset(); req = 1'b1;
    for (int k = 0; k < N; k++) tick();
    idle(); lddone = 1'b1;
    tick(); tick(); idle(); cdone = 1'b1;
    tick(); idle();
    #1;
    chk("inflight state", if0.tag_state, 8'h5B);
    rst_n = 1'b0;
    {req, bdone, lddone, cdone, sdone} = '1;
    tick(); rst_n = 1'b1; idle();
    #1;
    chk("midreset state", {if0.tag_state, if1.tag_state}, 16'h0);
    chk("midreset ptrs", {if0.tag_done, if0.tag, if0.ldmem_tag, if0.compute_tag, if0.stmem_tag}, 9'h100);
    // randomized traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      rst_n = ($urandom % 300) != 0;
      req = 1'($urandom); reuse = ($urandom % 3) == 0;
      bias = 1'($urandom); ddr = 1'($urandom);
      bdone = ($urandom % 5) == 0;
      lddone = 1'($urandom); cdone = 1'($urandom); sdone = 1'($urandom);
      raw = TW'($urandom);
      tick();
    end
    rst_n = 1'b1; idle();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
